chargen: RTL and testbench

CHARGEN -- requirements
Module: chargen

---
 rtl/chargen_pkg.sv | 30 +++
 rtl/glyph_shifter.sv | 45 ++++
 rtl/chargen.sv | 97 +++++++++
 tb/tb_chargen.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/chargen_pkg.sv
// Shared constants and types for the character generator.
// Text RAM attribute layout, pipeline depth and address widths.
package chargen_pkg;

  localparam int GLYPH_W  = 8;
  localparam int PIPE_LAT = 5;
  localparam int TEXT_AW  = 13;
  localparam int FONT_AW  = 9;
  localparam int FRAME_W  = 5;

  localparam int TD_INV      = 7;
  localparam int TD_BLINK    = 6;
  localparam int TD_GLYPH_HI = 5;
  localparam int TD_GLYPH_LO = 0;

  localparam int GLYPH_IW = TD_GLYPH_HI - TD_GLYPH_LO + 1;

  typedef struct packed {
    logic inv;
    logic blink;
  } attr_t;

  function automatic attr_t td_attr(input logic [7:0] td);
    attr_t a;
    a.inv   = td[TD_INV];
    a.blink = td[TD_BLINK];
    return a;
  endfunction

endpackage

// File: rtl/glyph_shifter.sv
// Pixel shifter: loads one font row plus attributes, emits MSB first.
// Ports: clk, rst_n, load, font, attr, blink_phase, act -> pix.
module glyph_shifter
  import chargen_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [GLYPH_W-1:0] font,
  input  attr_t              attr,
  input  logic               blink_phase,
  input  logic               act,
  output logic               pix
);

  logic [GLYPH_W-1:0] shift_q;
  // Marks which shifter bits still belong to a fetched glyph, so
  // stale attributes never paint pixels once the glyph is used up.
  logic [GLYPH_W-1:0] vmask_q;
  attr_t              attr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q <= '0;
      vmask_q <= '0;
      attr_q  <= '0;
    end else if (load) begin
      shift_q <= font;
      vmask_q <= '1;
      attr_q  <= attr;
    end else begin
      shift_q <= {shift_q[GLYPH_W-2:0], 1'b0};
      vmask_q <= {vmask_q[GLYPH_W-2:0], 1'b0};
    end
  end

  always_comb begin
    pix = shift_q[GLYPH_W-1] ^ attr_q.inv;
    if (attr_q.blink && blink_phase)
      pix = attr_q.inv;
    if (!act || !vmask_q[GLYPH_W-1])
      pix = 1'b0;
  end

endmodule

// File: rtl/chargen.sv
// Text-mode character generator: text RAM -> font RAM -> pixels.
// Ports: video timing in, two RAM read ports, pix and syncs out.
module chargen
  import chargen_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               active,
  input  logic [9:0]         hpos,
  input  logic [9:0]         vpos,
  input  logic               hsync_in,
  input  logic               vsync_in,
  output logic               text_rd,
  output logic [TEXT_AW-1:0] text_addr,
  input  logic [7:0]         text_data,
  output logic               rd,
  output logic [FONT_AW-1:0] rd_addr,
  input  logic [GLYPH_W-1:0] rd_data,
  output logic               pix,
  output logic               hsync_out,
  output logic               vsync_out
);

  logic                fetch;
  logic [PIPE_LAT-1:0] act_dl;
  logic [PIPE_LAT-1:0] hs_dl;
  logic [PIPE_LAT-1:0] vs_dl;
  logic [2:0]          row_d1;
  logic [2:0]          row_d2;
  logic                txt_vld;
  logic                fnt_vld;
  attr_t               attr_d1;
  attr_t               attr_d2;
  logic                vs_prev;
  logic [FRAME_W-1:0]  frame_q;
  logic                unused_vpos;

  // Row 512+ aliases rows 0-511.
  assign unused_vpos = vpos[9];

  assign fetch = active && (hpos[2:0] == 3'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      text_rd   <= 1'b0;
      text_addr <= '0;
      rd        <= 1'b0;
      rd_addr   <= '0;
      row_d1    <= '0;
      row_d2    <= '0;
      txt_vld   <= 1'b0;
      fnt_vld   <= 1'b0;
      attr_d1   <= '0;
      attr_d2   <= '0;
      act_dl    <= '0;
      hs_dl     <= '0;
      vs_dl     <= '0;
      vs_prev   <= 1'b0;
      frame_q   <= '0;
    end else begin
      text_rd <= fetch;
      if (fetch)
        text_addr <= {vpos[8:3], hpos[9:3]};
      row_d1  <= vpos[2:0];
      row_d2  <= row_d1;
      txt_vld <= text_rd;
      rd      <= txt_vld;
      if (txt_vld) begin
        rd_addr <= {text_data[TD_GLYPH_HI:TD_GLYPH_LO], row_d2};
        attr_d1 <= td_attr(text_data);
      end
      attr_d2 <= attr_d1;
      fnt_vld <= rd;
      act_dl  <= {act_dl[PIPE_LAT-2:0], active};
      hs_dl   <= {hs_dl[PIPE_LAT-2:0], hsync_in};
      vs_dl   <= {vs_dl[PIPE_LAT-2:0], vsync_in};
      vs_prev <= vsync_in;
      if (vsync_in && !vs_prev)
        frame_q <= frame_q + FRAME_W'(1);
    end
  end

  assign hsync_out = hs_dl[PIPE_LAT-1];
  assign vsync_out = vs_dl[PIPE_LAT-1];

  glyph_shifter u_shift (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (fnt_vld),
    .font       (rd_data),
    .attr       (attr_d2),
    .blink_phase(frame_q[FRAME_W-1]),
    .act        (act_dl[PIPE_LAT-1]),
    .pix        (pix)
  );

endmodule

// File: tb/tb_chargen.sv
// Directed bench for chargen with behavioural text and font RAMs.
// Checks fetch addresses, pixel streams, syncs, blink and reset.
module tb_chargen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        active = 1'b0;
  logic [9:0]  hpos = '0;
  logic [9:0]  vpos = '0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic        text_rd;
  logic [12:0] text_addr;
  logic [7:0]  text_data = '0;
  logic        rd;
  logic [8:0]  rd_addr;
  logic [7:0]  rd_data = '0;
  logic        pix;
  logic        hsync_out;
  logic        vsync_out;

  logic [7:0] tmem [0:8191];
  logic [7:0] fmem [0:511];
  logic       pixbuf [0:1023];

  int checks = 0;
  int errors = 0;
  int n_trd, n_frd, hs_bad;
  logic [12:0] first_ta;
  logic [8:0]  first_ra;
  logic        tail;

  always #5 clk = ~clk;

  always @(posedge clk) if (text_rd) text_data <= tmem[text_addr];
  always @(posedge clk) if (rd) rd_data <= fmem[rd_addr];

  chargen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .active   (active),
    .hpos     (hpos),
    .vpos     (vpos),
    .hsync_in (hsync_in),
    .vsync_in (vsync_in),
    .text_rd  (text_rd),
    .text_addr(text_addr),
    .text_data(text_data),
    .rd       (rd),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .pix      (pix),
    .hsync_out(hsync_out),
    .vsync_out(vsync_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int base, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) r = {r[30:0], pixbuf[base+i]};
    return r;
  endfunction

  // Drive ncyc active pixels from h0 on row v, then idle 5 cycles.
  task automatic run(input int h0, input int v, input int ncyc,
                     input int rst_at);
    logic hsh [0:1023];
    logic got_ta, got_ra;
    n_trd = 0; n_frd = 0; hs_bad = 0;
    got_ta = 0; got_ra = 0;
    first_ta = '1; first_ra = '1;
    for (int k = 0; k < ncyc + 5; k++) begin
      if (k < ncyc) begin
        active = 1'b1;
        hpos = 10'(h0 + k);
        vpos = 10'(v);
        hsync_in = ((k % 96) < 12);
      end else begin
        active = 1'b0;
        hpos = '0;
        hsync_in = 1'b0;
      end
      hsh[k] = hsync_in;
      rst_n = (k == rst_at) ? 1'b0 : 1'b1;
      tick();
      if (text_rd) begin
        n_trd++;
        if (!got_ta) begin first_ta = text_addr; got_ta = 1; end
      end
      if (rd) begin
        n_frd++;
        if (!got_ra) begin first_ra = rd_addr; got_ra = 1; end
      end
      if (k >= 4 && hsync_out !== hsh[k-4]) hs_bad++;
      if (k >= 4 && k - 4 < ncyc) pixbuf[k-4] = pix;
    end
    rst_n = 1'b1;
    tail = pix;
  endtask

  task automatic vs_pulses(input int n);
    logic vh [0:127];
    int bad = 0;
    for (int k = 0; k < 2 * n + 5; k++) begin
      vsync_in = (k < 2 * n) && (k % 2 == 0);
      vh[k] = vsync_in;
      tick();
      if (k >= 4 && vsync_out !== vh[k-4]) bad++;
    end
    chk("vsync_dly", 32'(bad), 0);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) tmem[i] = '0;
    for (int i = 0; i < 512; i++) fmem[i] = '0;

    rst_n = 1'b0;
    tick(); tick(); tick();
    chk("rst_text_rd", 32'(text_rd), 0);
    chk("rst_rd", 32'(rd), 0);
    chk("rst_pix", 32'(pix), 0);
    chk("rst_hsync", 32'(hsync_out), 0);
    chk("rst_vsync", 32'(vsync_out), 0);
    chk("rst_text_addr", 32'(text_addr), 0);
    chk("rst_rd_addr", 32'(rd_addr), 0);
    rst_n = 1'b1;
    tick();

    tmem[0] = 8'h05;
    fmem[9'h02B] = 8'hA5;
    run(0, 3, 8, -1);
    chk("single_taddr", 32'(first_ta), 0);
    chk("single_raddr", 32'(first_ra), 32'h02B);
    chk("single_pix", pk(0, 8), 32'hA5);
    chk("single_tail", 32'(tail), 0);
    chk("single_ntrd", 32'(n_trd), 1);
    chk("single_nfrd", 32'(n_frd), 1);
    chk("single_hsync", 32'(hs_bad), 0);

    tmem[0] = 8'h85;
    run(0, 3, 8, -1);
    chk("inverse_pix", pk(0, 8), 32'h5A);
    chk("inverse_tail", 32'(tail), 0);

    tmem[0] = 8'h05;
    run(0, 512 + 3, 8, -1);
    chk("alias_taddr", 32'(first_ta), 0);
    chk("alias_raddr", 32'(first_ra), 32'h02B);
    chk("alias_pix", pk(0, 8), 32'hA5);

    tmem[1] = 8'h05;
    run(3, 3, 13, -1);
    chk("unalign_pix", pk(0, 13), 32'h0A5);
    chk("unalign_ntrd", 32'(n_trd), 1);
    chk("unalign_taddr", 32'(first_ta), 1);

    tmem[0] = 8'h45;
    fmem[9'h02B] = 8'hFF;
    run(0, 3, 8, -1);
    chk("blink_ph0_pix", pk(0, 8), 32'hFF);
    vs_pulses(16);
    run(0, 3, 8, -1);
    chk("blink_16_pix", pk(0, 8), 32'h00);
    vs_pulses(16);
    run(0, 3, 8, -1);
    chk("blink_32_pix", pk(0, 8), 32'hFF);

    for (int i = 0; i < 80; i++) tmem[256+i] = 8'(i % 64);
    for (int g = 0; g < 64; g++) fmem[g*8] = 8'((g * 37 + 11) & 255);
    run(0, 16, 640, -1);
    chk("line_ntrd", 32'(n_trd), 80);
    chk("line_nfrd", 32'(n_frd), 80);
    chk("line_taddr", 32'(first_ta), 256);
    chk("line_hsync", 32'(hs_bad), 0);
    chk("line_tail", 32'(tail), 0);
    for (int i = 0; i < 80; i++)
      chk($sformatf("line_char%0d", i), pk(i * 8, 8),
          32'(((i % 64) * 37 + 11) & 255));

    tmem[0] = 8'h45;
    tmem[1] = 8'h45;
    vs_pulses(15);
    run(0, 3, 16, 7);
    chk("midrst_pix", pk(0, 16), 32'hE0FF);
    chk("midrst_ntrd", 32'(n_trd), 2);
    vs_pulses(1);
    run(0, 3, 8, -1);
    chk("midrst_frame", pk(0, 8), 32'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
